// File: rtl/ipif_arb_pkg.sv
// Shared types and constants for the IPIF burst command arbiter.
package ipif_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 20;
    localparam int BE_W   = 8;

    localparam logic            MST_TYPE_BURST = 1'b1;
    localparam logic [BE_W-1:0] BE_ALL         = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_XFER = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ipif_burst_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i wins.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic              valid_o
);

    int               pos_s;
    logic [PTR_W-1:0] idx_s;
    logic             hit_s;
    logic             found_s;

    // Walk the channels starting at ptr_i, wrapping once, and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        found_s = 1'b0;
        pos_s   = 0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            pos_s        = int'(ptr_i) + i;
            pos_s        = (pos_s >= NUM_CH) ? (pos_s - NUM_CH) : pos_s;
            idx_s        = PTR_W'(pos_s);
            hit_s        = req_i[idx_s] & ~found_s;
            gnt_o[idx_s] = hit_s;
            found_s      = found_s | hit_s;
        end
        valid_o = found_s;
    end

endmodule

// File: rtl/ipif_burst_arbiter.sv
// Shares the single IPIF master command port among NUM_CH DMA clients,
// one burst at a time, with round-robin priority and a command watchdog.
module ipif_burst_arbiter
    import ipif_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    Clk,
    input  logic                    ResetL,
    input  logic [NUM_CH-1:0]       ch_req,
    input  logic [NUM_CH-1:0]       ch_rnw,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LEN_W-1:0] ch_len,
    output logic [NUM_CH-1:0]       ch_ack,
    output logic [NUM_CH-1:0]       ch_done,
    output logic [NUM_CH-1:0]       ch_err,
    output logic [NUM_CH-1:0]       ch_grant,
    output logic                    busy,
    output logic                    ip2bus_mstrd_req,
    output logic                    ip2bus_mstwr_req,
    output logic [ADDR_W-1:0]       ip2bus_mst_addr,
    output logic [LEN_W-1:0]        ip2bus_mst_length,
    output logic [BE_W-1:0]         ip2bus_mst_be,
    output logic                    ip2bus_mst_type,
    output logic                    ip2bus_mst_lock,
    output logic                    ip2bus_mst_reset,
    input  logic                    bus2ip_mst_cmdack,
    input  logic                    bus2ip_mst_cmplt,
    input  logic                    bus2ip_mst_error
);

    localparam int PTR_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e          state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [CNT_W-1:0]    wdog_q;
    logic [NUM_CH-1:0]   grant_q, ack_q, done_q, err_q;
    logic                rd_req_q, wr_req_q, mst_reset_q, rnw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LEN_W-1:0]    len_q;

    logic [NUM_CH-1:0]   win_s;
    logic                win_vld_s;
    logic [PTR_W-1:0]    win_idx_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [LEN_W-1:0]    win_len_s;
    logic                win_rnw_s;
    logic                wd_expire_s;
    logic [NUM_CH-1:0]   cmplt_err_s;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req_i   (ch_req),
        .ptr_i   (ptr_q),
        .gnt_o   (win_s),
        .valid_o (win_vld_s)
    );

    // Winner is one-hot, so OR-ing masked channel fields selects its command.
    always_comb begin
        win_idx_s  = '0;
        win_addr_s = '0;
        win_len_s  = '0;
        win_rnw_s  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            win_idx_s  = win_idx_s  | (PTR_W'(i) & {PTR_W{win_s[i]}});
            win_addr_s = win_addr_s | (ch_addr[ADDR_W*i +: ADDR_W] & {ADDR_W{win_s[i]}});
            win_len_s  = win_len_s  | (ch_len[LEN_W*i +: LEN_W] & {LEN_W{win_s[i]}});
            win_rnw_s  = win_rnw_s  | (ch_rnw[i] & win_s[i]);
        end
        ptr_d       = (win_idx_s == LAST_CH) ? '0 : (win_idx_s + 1'b1);
        wd_expire_s = (wdog_q == WD_LAST);
        cmplt_err_s = grant_q & {NUM_CH{bus2ip_mst_error}};
    end

    // Command sequencer; every output is a flop updated here.
    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            wdog_q      <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            mst_reset_q <= 1'b0;
            rnw_q       <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
        end else begin
            ack_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            mst_reset_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    wdog_q <= '0;
                    if (win_vld_s) begin
                        grant_q <= win_s;
                        rnw_q   <= win_rnw_s;
                        addr_q  <= win_addr_s;
                        len_q   <= win_len_s;
                        ptr_q   <= ptr_d;
                        // A zero-length command never reaches the bus; it fails in GAP.
                        if (win_len_s == '0) begin
                            state_q <= ST_GAP;
                            done_q  <= win_s;
                            err_q   <= win_s;
                        end else begin
                            state_q  <= ST_CMD;
                            rd_req_q <= win_rnw_s;
                            wr_req_q <= ~win_rnw_s;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_CMD: begin
                    wdog_q <= wd_expire_s ? wdog_q : (wdog_q + 1'b1);
                    if (bus2ip_mst_cmplt) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        ack_q    <= grant_q;
                        done_q   <= grant_q;
                        err_q    <= cmplt_err_s;
                        state_q  <= ST_GAP;
                    end else if (bus2ip_mst_cmdack) begin
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        ack_q    <= grant_q;
                        state_q  <= ST_XFER;
                    end else if (wd_expire_s) begin
                        rd_req_q    <= 1'b0;
                        wr_req_q    <= 1'b0;
                        done_q      <= grant_q;
                        err_q       <= grant_q;
                        mst_reset_q <= 1'b1;
                        state_q     <= ST_GAP;
                    end else begin
                        state_q <= ST_CMD;
                    end
                end
                ST_XFER: begin
                    wdog_q <= wd_expire_s ? wdog_q : (wdog_q + 1'b1);
                    if (bus2ip_mst_cmplt) begin
                        done_q  <= grant_q;
                        err_q   <= cmplt_err_s;
                        state_q <= ST_GAP;
                    end else if (wd_expire_s) begin
                        done_q      <= grant_q;
                        err_q       <= grant_q;
                        mst_reset_q <= 1'b1;
                        state_q     <= ST_GAP;
                    end else begin
                        state_q <= ST_XFER;
                    end
                end
                ST_GAP: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q  <= '0;
                    rd_req_q <= 1'b0;
                    wr_req_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ch_ack            = ack_q;
    assign ch_done           = done_q;
    assign ch_err            = err_q;
    assign ch_grant          = grant_q;
    assign busy              = (state_q != ST_IDLE);
    assign ip2bus_mstrd_req  = rd_req_q;
    assign ip2bus_mstwr_req  = wr_req_q;
    assign ip2bus_mst_addr   = addr_q;
    assign ip2bus_mst_length = len_q;
    assign ip2bus_mst_be     = BE_ALL;
    assign ip2bus_mst_type   = MST_TYPE_BURST;
    assign ip2bus_mst_lock   = 1'b0;
    assign ip2bus_mst_reset  = mst_reset_q;

endmodule

// File: doc/ipif_burst_arbiter.md
# ipif_burst_arbiter

Command-phase arbiter and sequencer for the AXI Master Burst IPIF. Shares the single IPIF master command port among NUM_CH DMA clients (frame fetch, frame store, etc.) with round-robin priority. Issues one read or write burst command at a time, tracks cmdack and cmplt, and reports per-channel ack/done/error. Grants stream ownership so the winning client drives or consumes the LocalLink data path directly.

## Interface
- NUM_CH, 4: number of client channels (2..8)
- TIMEOUT, 1024: cycles allowed from command issue to cmplt before abort
- Clk  in  1  system clock, all logic rising-edge
- ResetL  in  1  asynchronous, active-low reset
- ch_req  in  NUM_CH  per-channel command request, level
- ch_rnw  in  NUM_CH  1 = read burst, 0 = write burst
- ch_addr  in  NUM_CH*32  byte address, channel i at [32i+31:32i]
- ch_len  in  NUM_CH*20  byte length, channel i at [20i+19:20i]
- ch_ack  out  NUM_CH  one-cycle pulse, command accepted by IPIF
- ch_done  out  NUM_CH  one-cycle pulse, transfer finished
- ch_err  out  NUM_CH  one-cycle pulse coincident with ch_done on failure
- ch_grant  out  NUM_CH  one-hot, channel owns LocalLink stream
- busy  out  1  high in any state except IDLE
- ip2bus_mstrd_req / ip2bus_mstwr_req  out  1 each  IPIF command requests
- ip2bus_mst_addr  out  32;  ip2bus_mst_length  out  20;  ip2bus_mst_be  out  8 (constant 8'hFF)
- ip2bus_mst_type  out  1 (constant 1, burst);  ip2bus_mst_lock  out  1 (constant 0)
- ip2bus_mst_reset  out  1  one-cycle abort pulse after timeout
- bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error  in  1 each

## Operation
- States: IDLE, CMD, XFER, GAP.
- IDLE: if any ch_req, select winner by round-robin starting at ptr; register winner one-hot, rnw, addr, len; go to CMD. ptr <= winner+1 (mod NUM_CH) on selection.
- Zero length: winner with len==0 goes IDLE->GAP, no IPIF request; ch_done+ch_err pulse in GAP.
- CMD: drive mstrd_req (rnw=1) or mstwr_req (rnw=0) with registered addr/length; on cmdack -> XFER, pulse ch_ack.
- cmdack and cmplt in the same cycle, or cmplt while in CMD: treat as ack then done -> GAP, ch_ack and ch_done both pulse.
- XFER: requests low; on cmplt -> GAP; ch_err = bus2ip_mst_error sampled with cmplt.
- Watchdog: counter cleared on IDLE exit, counts in CMD and XFER; reaching TIMEOUT -> GAP with ch_err, ip2bus_mst_reset pulsed in GAP.
- GAP: exactly one cycle; ch_done (+ch_err) pulse; grant drops; -> IDLE. Guarantees requests low at least 2 cycles between commands (IPIF edge-detects requests).
- Clients: drop ch_req after ch_ack; a ch_req still high in IDLE is a new request. ch_req of the granted channel is ignored outside IDLE.

## Timing
- Reset values: all outputs 0 except ip2bus_mst_be=8'hFF, ip2bus_mst_type=1; ptr=0; state IDLE. Asynchronous: assertion mid-transfer clears immediately, no done pulse.
- ch_req sampled cycle n in IDLE -> ip2bus req and ch_grant high at n+1.
- cmdack sampled cycle m -> req low and ch_ack high at m+1.
- cmplt sampled cycle k -> GAP at k+1 (ch_done pulse, grant high); IDLE at k+2; earliest next req at k+3.
- addr/length/rnw stable from CMD entry to GAP exit.
- Watchdog compare is count == TIMEOUT-1, width clog2(TIMEOUT+1).

## Structure
- Package ipif_arb_pkg: state enum, ADDR_W=32, LEN_W=20, BE_W=8, MST_TYPE_BURST=1, BE_ALL=8'hFF.
- Sub-module rr_arbiter: combinational NUM_CH round-robin pick from req vector and ptr, outputs one-hot winner and valid.

## Test plan
- Single read, ch0 req addr 0x1000 len 256, cmdack 3 cycles later, cmplt at +70 -> mstrd_req high 3 cycles, ch_ack[0] once, ch_done[0] once, ch_err 0.
- All four channels req simultaneously, alternating rnw -> grants in order 0,1,2,3, then 0 again; mstrd/mstwr follow rnw; ≥2 idle-low cycles between requests.
- cmdack and cmplt same cycle on ch2 write -> ch_ack[2] and ch_done[2] same cycle, back to IDLE 2 cycles later.
- No cmplt, TIMEOUT=64 -> GAP at issue+64, ip2bus_mst_reset one pulse, ch_done+ch_err on granted channel.
- ch1 len 0 -> no IPIF request, ch_done[1]+ch_err[1] 2 cycles after req; bus2ip_mst_error=1 with cmplt -> ch_err pulse.
- ResetL low during XFER -> all outputs to reset values same cycle, ptr=0, next request served from ch0.
